uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BIT, default 8: width of one received character.
REQ-002 Parameter ADDR_WIDTH, default 4: FIFO depth = 2**ADDR_WIDTH entries (16).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port rx_done_tick, input, 1: one-cycle pulse from receiver; din valid this cycle.
REQ-006 Port din, input, DATA_BIT: received character from receiver.
REQ-007 Port framing_error, input, 1: one-cycle pulse from receiver; bad stop bit.
REQ-008 Port rd, input, 1: consumer pop request; head entry is consumed this cycle.
REQ-009 Port clr_err, input, 1: one-cycle pulse; clears the sticky error flags.
REQ-010 Port dout, output, DATA_BIT: head entry in first-word-fall-through mode.
REQ-011 Port dout_err, output, 1: framing-error tag of the head entry.
REQ-012 Port empty, output, 1: no entries stored.
REQ-013 Port full, output, 1: 2**ADDR_WIDTH entries stored.
REQ-014 Port count, output, ADDR_WIDTH+1: number of entries stored.
REQ-015 Port overrun, output, 1: sticky flag; a write was dropped because the FIFO was full.
REQ-016 Port frame_err, output, 1: sticky flag; at least one framing_error pulse was seen.

Function
REQ-017 Write request wr = rx_done_tick, plus framing_error when UART_RX_FIFO_ERR_TAG_EN is defined; accepted when not full, or when full and rd is accepted in the same cycle.
REQ-018 Accepted write stores the entry at wr_ptr; wr_ptr increments modulo 2**ADDR_WIDTH.
REQ-019 rd is accepted only when empty=0; rd while empty is ignored with no pointer, count or flag change.
REQ-020 Accepted read increments rd_ptr modulo 2**ADDR_WIDTH.
REQ-021 Write to empty FIFO: empty deasserts and dout/dout_err show the new entry one cycle after the write edge (1-cycle latency).
REQ-022 dout/dout_err are combinational from the head entry; both are undefined-free (hold last memory contents) when empty=1.
REQ-023 count: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted; full = (count == 2**ADDR_WIDTH), empty = (count == 0).
REQ-024 Simultaneous write and read while empty: write accepted, read ignored.
REQ-025 Simultaneous write and read while full: both accepted; full stays 1; no overrun.
REQ-026 Write while full without rd: data dropped, overrun set on the next edge.
REQ-027 overrun and frame_err stay set until clr_err; a set event in the same cycle as clr_err wins (flag stays 1).
REQ-028 rx_done_tick and framing_error in the same cycle: treated as one write of din with dout_err=1 (when the macro is defined); frame_err is set.

Reset
REQ-029 On rst: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, frame_err=0; memory contents are not reset.
REQ-030 rst asserted mid-operation discards all stored entries immediately; din and rd are ignored while rst=1.

Configuration
REQ-031 Macro UART_RX_FIFO_ERR_TAG_EN defined: each entry stores an extra tag bit; a framing_error pulse writes an entry with data = 0 (or din if coincident with rx_done_tick) and tag = 1; dout_err reflects the head tag.
REQ-032 Macro undefined: no tag storage; framing_error only sets frame_err and writes nothing; dout_err is tied to 0.

Structure
REQ-033 Shared package uart_pkg holds the DATA_BIT default, the FIFO ADDR_WIDTH default and the derived depth constant.
REQ-034 Storage is sub-module uart_fifo_mem: a register array with one synchronous write port and one combinational read port; pointers, count and flags stay in uart_rx_fifo.

Verification
REQ-035 Reset, then 3 writes (0x41, 0x42, 0x43), then 3 reads -> dout sequence 0x41, 0x42, 0x43; count 3->0; empty=1 at the end.
REQ-036 17 writes with no reads -> full=1 after the 16th write; the 17th is dropped; overrun=1; 16 reads return the first 16 bytes in order.
REQ-037 Full FIFO, rd plus write of 0x55 in the same cycle -> full stays 1, overrun=0, 0x55 is read last.
REQ-038 Empty FIFO, rd plus write of 0xA5 in the same cycle -> count=1, dout=0xA5 on the next cycle.
REQ-039 framing_error pulse with the macro defined -> one entry, dout=0x00, dout_err=1, frame_err=1; clr_err -> frame_err=0. Same stimulus with the macro undefined -> empty stays 1.
REQ-040 Assert rst with 5 entries stored -> empty=1 and count=0 immediately; a following write of 0x10 reads back 0x10.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared constants for the UART receive path.
//
// Holds the default character width, the default receive-FIFO address
// width and the FIFO depth derived from it. Imported by uart_rx_fifo and
// uart_fifo_mem so both agree on the defaults.
package uart_pkg;

  localparam int DATA_BIT_DEFAULT   = 8;
  localparam int ADDR_WIDTH_DEFAULT = 4;
  localparam int FIFO_DEPTH_DEFAULT = 2 ** ADDR_WIDTH_DEFAULT;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem -- storage array for the UART receive FIFO.
//
// Register array with one synchronous write port and one combinational
// read port. Contents are never reset; the read port simply shows whatever
// was last written at raddr.
//
// Ports:
//   clk    : clock, writes happen on the rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data (WIDTH bits)
//   raddr  : read address
//   rdata  : combinational read data at raddr
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH      = DATA_BIT_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- first-word-fall-through FIFO behind a UART receiver.
//
// Buffers received characters, keeps sticky overrun / framing-error flags
// and presents the head entry combinationally on dout.
//
// Optional feature: define UART_RX_FIFO_ERR_TAG_EN to store a framing-error
// tag bit with every entry. With it, a framing_error pulse itself writes an
// entry (data 0, or din when coincident with rx_done_tick) tagged 1, and
// dout_err shows the head tag. Without it, framing_error only sets
// frame_err and dout_err is tied low.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   rx_done_tick   : receiver strobe, din valid this cycle
//   din            : received character
//   framing_error  : receiver strobe, bad stop bit
//   rd             : pop the head entry (ignored while empty)
//   clr_err        : clear the sticky flags
//   dout, dout_err : head entry data / tag
//   empty, full    : occupancy flags
//   count          : number of entries stored
//   overrun        : sticky, a write was dropped because the FIFO was full
//   frame_err      : sticky, a framing_error pulse was seen
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BIT   = DATA_BIT_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_done_tick,
  input  logic [DATA_BIT-1:0]   din,
  input  logic                  framing_error,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [DATA_BIT-1:0]   dout,
  output logic                  dout_err,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int ENTRY_W = DATA_BIT + 1;
`else
  localparam int ENTRY_W = DATA_BIT;
`endif

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  overrun_reg, frame_err_reg;

  logic                  wr_req, wr_ok, rd_ok;
  logic [ENTRY_W-1:0]    wdata, rdata;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  // A lone framing_error stores a zero character tagged as bad.
  assign wr_req   = rx_done_tick | framing_error;
  assign wdata    = {framing_error, (rx_done_tick ? din : {DATA_BIT{1'b0}})};
  assign dout     = rdata[DATA_BIT-1:0];
  assign dout_err = rdata[DATA_BIT];
`else
  assign wr_req   = rx_done_tick;
  assign wdata    = din;
  assign dout     = rdata;
  assign dout_err = 1'b0;
`endif

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);
  assign count = count_reg;
  assign overrun   = overrun_reg;
  assign frame_err = frame_err_reg;

  // A read frees the head slot in the same cycle, so a write to a full
  // FIFO still lands when paired with an accepted read.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr_req & (~full | rd_ok);

  uart_fifo_mem #(
    .WIDTH      (ENTRY_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Set events take priority over a coincident clear.
      overrun_reg   <= (wr_req & ~wr_ok) | (overrun_reg & ~clr_err);
      frame_err_reg <= framing_error | (frame_err_reg & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- self-checking bench for uart_rx_fifo.
//
// Directed table, hand-written corner sequences and a randomized phase
// checked against a queue-based reference model. Honours
// UART_RX_FIFO_ERR_TAG_EN the same way the design does.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic       framing_error = 1'b0;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic       dout_err, empty, full, overrun, frame_err;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .rx_done_tick  (rx_done_tick),
    .din           (din),
    .framing_error (framing_error),
    .rd            (rd),
    .clr_err       (clr_err),
    .dout          (dout),
    .dout_err      (dout_err),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overrun       (overrun),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns at posedge+1 with strobes cleared.
  task automatic step(input logic rx, input logic [7:0] d, input logic fe,
                      input logic r, input logic c);
    rx_done_tick  = rx;
    din           = d;
    framing_error = fe;
    rd            = r;
    clr_err       = c;
    @(posedge clk);
    #1;
    rx_done_tick  = 1'b0;
    framing_error = 1'b0;
    rd            = 1'b0;
    clr_err       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rx;
    logic [7:0] din;
    logic       rd;
    logic [4:0] cnt;
    logic [7:0] dout;
  } vec_t;

  typedef struct {
    logic       tag;
    logic [7:0] data;
  } ent_t;

  vec_t vecs[9];
  ent_t q[$];
  bit   m_ovr, m_fe;

  initial begin
    // rx, din, rd, expected count, expected head (checked when count>0)
    vecs[0] = '{1'b1, 8'h41, 1'b0, 5'd1, 8'h41};
    vecs[1] = '{1'b1, 8'h42, 1'b0, 5'd2, 8'h41};
    vecs[2] = '{1'b1, 8'h43, 1'b0, 5'd3, 8'h41};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd2, 8'h42};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd1, 8'h43};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00};  // rd while empty ignored
    vecs[7] = '{1'b1, 8'hA5, 1'b1, 5'd1, 8'hA5};  // rd+write while empty
    vecs[8] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00};

    // Reset state
    #3;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_err", frame_err, 0);
    do_reset();

    // Directed table
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rx, vecs[i].din, 1'b0, vecs[i].rd, 1'b0);
      $display("vec %0d rx=%0b din=%02h rd=%0b -> count=%0d empty=%0b dout=%02h",
               i, vecs[i].rx, vecs[i].din, vecs[i].rd, count, empty, dout);
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_empty", i), empty, (vecs[i].cnt == 0) ? 1 : 0);
      chk($sformatf("vec%0d_full", i), full, 0);
      chk($sformatf("vec%0d_overrun", i), overrun, 0);
      if (vecs[i].cnt != 0) chk($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
    end

    // 17 writes, 17th dropped, then 16 ordered reads
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      $display("fill write %0d din=%02h count=%0d full=%0b overrun=%0b",
               i, 8'h60 + i, count, full, overrun);
      if (i == 14) chk("fill15_full", full, 0);
      if (i == 15) chk("fill16_full", full, 1);
    end
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_overrun", overrun, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_rd%0d_dout", i), dout, 8'h60 + i);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      $display("drain read %0d count=%0d", i, count);
    end
    chk("ovf_drained_empty", empty, 1);
    chk("ovf_overrun_sticky", overrun, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr_overrun", overrun, 0);

    // Full FIFO: read and write in the same cycle
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    $display("full rd+wr 55 count=%0d full=%0b overrun=%0b", count, full, overrun);
    chk("fullrw_full", full, 1);
    chk("fullrw_overrun", overrun, 0);
    chk("fullrw_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullrw_rd%0d", i), dout, (i == 15) ? 8'h55 : 8'h21 + i);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("fullrw_empty", empty, 1);

    // Lone framing error, clear, and set-wins-over-clear
    do_reset();
    step(1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
    $display("framing_error pulse count=%0d dout=%02h dout_err=%0b frame_err=%0b",
             count, dout, dout_err, frame_err);
    chk("fe_frame_err", frame_err, 1);
    if (TAG_EN) begin
      chk("fe_count", count, 1);
      chk("fe_dout", dout, 0);
      chk("fe_dout_err", dout_err, 1);
    end else begin
      chk("fe_empty", empty, 1);
      chk("fe_dout_err", dout_err, 0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("fe_clr", frame_err, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("fe_set_wins", frame_err, 1);
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("fe_coincident_count", count, TAG_EN ? 3 : 1);

    // Asynchronous reset with 5 entries stored
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    chk("arst_pre_count", count, 5);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-cycle count=%0d empty=%0b", count, empty);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    rx_done_tick = 1'b1; din = 8'h77; rd = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_hold_count", count, 0);
    rx_done_tick = 1'b0; rd = 1'b0;
    rst = 1'b0;
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    chk("arst_wr_dout", dout, 8'h10);
    chk("arst_wr_count", count, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("arst_rd_empty", empty, 1);

    // Randomized traffic against a queue model
    do_reset();
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic       r_rx, r_fe, r_rd, r_clr, m_wr, m_rdok, m_full;
      logic [7:0] r_din;
      r_rx  = ($urandom_range(0, 99) < 50);
      r_din = 8'($urandom);
      r_fe  = ($urandom_range(0, 99) < 6);
      r_rd  = ($urandom_range(0, 99) < ((cyc % 200) < 100 ? 25 : 70));
      r_clr = ($urandom_range(0, 99) < 5);

      m_full = (q.size() == 16);
      m_wr   = r_rx | (TAG_EN & r_fe);
      m_rdok = r_rd && (q.size() > 0);
      if (m_rdok) void'(q.pop_front());
      if (m_wr) begin
        if (!m_full || m_rdok) q.push_back('{r_fe & TAG_EN, r_rx ? r_din : 8'h00});
        else m_ovr = 1'b1;
      end else if (r_clr) begin
        m_ovr = 1'b0;
      end
      if (m_wr && m_full && !m_rdok) m_ovr = 1'b1;
      else if (r_clr) m_ovr = 1'b0;
      m_fe = r_fe ? 1'b1 : (r_clr ? 1'b0 : m_fe);

      step(r_rx, r_din, r_fe, r_rd, r_clr);
      $display("rand %0d rx=%0b din=%02h fe=%0b rd=%0b clr=%0b -> count=%0d dout=%02h",
               cyc, r_rx, r_din, r_fe, r_rd, r_clr, count, dout);
      chk("rand_count", count, q.size());
      chk("rand_empty", empty, (q.size() == 0) ? 1 : 0);
      chk("rand_full", full, (q.size() == 16) ? 1 : 0);
      chk("rand_overrun", overrun, m_ovr);
      chk("rand_frame_err", frame_err, m_fe);
      if (q.size() > 0) begin
        chk("rand_dout", dout, q[0].data);
        chk("rand_dout_err", dout_err, q[0].tag);
      end else if (!TAG_EN) begin
        chk("rand_dout_err_tied", dout_err, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
